// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the triggered ADC waveform capture block.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_LEVEL = 2'd1,
    SRC_EXT   = 2'd2,
    SRC_FORCE = 2'd3
  } trig_src_t;

  // What the second readout stage presents on wavesample.
  typedef enum logic [1:0] {
    RD_ZERO   = 2'd0,
    RD_SAMPLE = 2'd1,
    RD_STATUS = 2'd2
  } rd_kind_t;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_FORCE = 1;
  localparam int CTRL_SRC   = 2;
  localparam int CTRL_POL   = 3;
  localparam int CTRL_ABORT = 4;

  localparam logic [15:0] STATUS_IDX = 16'hFFFF;

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port sample RAM: one write port, registered read, read-before-write.
module adc_capture_ram #(
  parameter int DEPTH = 1024,
  parameter int W     = 14,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_wave_capture.sv
// Triggered waveform capture: circular sample RAM with pre-trigger window,
// software/external/level triggering and a CPU readout port.
module adc_wave_capture
  import adc_capture_pkg::*;
#(
  parameter int                       DEPTH      = 1024,
  parameter int                       PRETRIG    = 128,
  parameter int                       ADC_W      = 14,
  parameter logic signed [ADC_W-1:0]  TRIG_LEVEL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic             ext_trig,
  input  logic [7:0]       ctrl,
  input  logic [15:0]      samplenum,
  output logic [15:0]      wavesample,
  output logic             busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] POST_LEN = (AW+1)'(DEPTH - PRETRIG);

  logic [4:0]   ctrl_reg, ctrl_dly, ctrl_rise;
  logic         ctrl_unused;
  cap_state_t   state;
  trig_src_t    trig_src;
  logic         done;
  logic [AW-1:0] wr_ptr, trig_ptr, wr_cnt;
  logic [AW:0]   post_cnt;
  logic signed [ADC_W-1:0] prev_sample, cur_sample;
  logic         prev_valid;
  logic         writing, rise_x, fall_x, level_hit, ext_hit, force_hit;

  assign ctrl_unused = ^ctrl[7:5];
  assign ctrl_rise   = ctrl_reg & ~ctrl_dly;
  assign busy        = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  assign writing     = busy && adc_valid;
  assign cur_sample  = adc_data;

  // Level crossing uses the last stored sample, even if it was written in PRE.
  assign rise_x    = prev_valid && (prev_sample <  TRIG_LEVEL) && (cur_sample >= TRIG_LEVEL);
  assign fall_x    = prev_valid && (prev_sample >= TRIG_LEVEL) && (cur_sample <  TRIG_LEVEL);
  assign level_hit = adc_valid && !ctrl_reg[CTRL_SRC] && (ctrl_reg[CTRL_POL] ? fall_x : rise_x);
  assign ext_hit   = adc_valid && ctrl_reg[CTRL_SRC] && ext_trig;
  assign force_hit = ctrl_rise[CTRL_FORCE];

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg    <= '0;
      ctrl_dly    <= '0;
      state       <= ST_IDLE;
      trig_src    <= SRC_NONE;
      done        <= 1'b0;
      wr_ptr      <= '0;
      trig_ptr    <= '0;
      wr_cnt      <= '0;
      post_cnt    <= '0;
      prev_sample <= '0;
      prev_valid  <= 1'b0;
    end else begin
      ctrl_reg <= ctrl[4:0];
      ctrl_dly <= ctrl_reg;
      if (writing) begin
        wr_ptr      <= wr_ptr + 1'b1;
        prev_sample <= cur_sample;
        prev_valid  <= 1'b1;
      end
      if (ctrl_rise[CTRL_ABORT]) begin
        state <= ST_IDLE;
        done  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (ctrl_rise[CTRL_ARM]) begin
              done       <= 1'b0;
              wr_cnt     <= '0;
              prev_valid <= 1'b0;
              trig_src   <= SRC_NONE;
              state      <= (PRETRIG == 0) ? ST_WAIT_TRIG : ST_PRE;
            end
          end
          ST_PRE: begin
            if (adc_valid) begin
              wr_cnt <= wr_cnt + 1'b1;
              if (wr_cnt == AW'(PRETRIG - 1)) state <= ST_WAIT_TRIG;
            end
          end
          ST_WAIT_TRIG: begin
            if (force_hit || ext_hit || level_hit) begin
              trig_ptr <= wr_ptr;
              trig_src <= force_hit ? SRC_FORCE : (ext_hit ? SRC_EXT : SRC_LEVEL);
              // A sample arriving with the trigger is the first POST sample.
              if (adc_valid) begin
                post_cnt <= POST_LEN - 1'b1;
                state    <= (POST_LEN == 1) ? ST_DONE : ST_POST;
                done     <= (POST_LEN == 1);
              end else begin
                post_cnt <= POST_LEN;
                state    <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (adc_valid) begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == 1) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Readout: stage 1 registers the index, stage 2 is the RAM output / status word.
  logic [15:0]      samplenum_reg, status_reg;
  rd_kind_t         kind_reg;
  logic [AW-1:0]    raddr;
  logic [ADC_W-1:0] rdata;

  assign raddr = trig_ptr - AW'(PRETRIG) + samplenum_reg[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      samplenum_reg <= '0;
      status_reg    <= '0;
      kind_reg      <= RD_ZERO;
    end else begin
      samplenum_reg <= samplenum;
      status_reg    <= {done, busy, state, 1'b0, trig_src, 8'h00};
      if (samplenum_reg == STATUS_IDX)        kind_reg <= RD_STATUS;
      else if (int'(samplenum_reg) < DEPTH)   kind_reg <= RD_SAMPLE;
      else                                    kind_reg <= RD_ZERO;
    end
  end

  adc_capture_ram #(.DEPTH(DEPTH), .W(ADC_W), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (writing),
    .waddr (wr_ptr),
    .wdata (adc_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    wavesample = '0;
    case (kind_reg)
      RD_SAMPLE: wavesample = {{(16-ADC_W){rdata[ADC_W-1]}}, rdata};
      RD_STATUS: wavesample = status_reg;
      default:   wavesample = '0;
    endcase
  end

endmodule

// File: tb/tb_adc_wave_capture.sv
// Directed bench for adc_wave_capture: level/external/force triggers, abort,
// readout boundaries and latency, reset mid-capture.
module tb_adc_wave_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] adc_data;
  logic        adc_valid;
  logic        ext_trig;
  logic [7:0]  ctrl;
  logic [15:0] samplenum;
  logic [15:0] wavesample;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_wave_capture dut (
    .clk        (clk),
    .reset      (reset),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .ext_trig   (ext_trig),
    .ctrl       (ctrl),
    .samplenum  (samplenum),
    .wavesample (wavesample),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] idx, output logic [15:0] val);
    samplenum = idx;
    cycles(2);
    val = wavesample;
  endtask

  task automatic send(input int n, input int val);
    for (int i = 0; i < n; i++) begin
      adc_data  = 14'(val);
      adc_valid = 1'b1;
      @(negedge clk);
    end
    adc_valid = 1'b0;
  endtask

  task automatic set_ctrl(input logic [7:0] v);
    ctrl = v;
    cycles(4);
  endtask

  logic [15:0] v;

  initial begin
    reset = 1'b1; adc_data = '0; adc_valid = 1'b0; ext_trig = 1'b0;
    ctrl = 8'h00; samplenum = 16'h0000;
    cycles(3);
    chk("reset_wavesample", wavesample, 16'h0000);
    chk("reset_busy", {15'd0, busy}, 16'h0000);
    reset = 1'b0;
    rd(16'hFFFF, v); chk("reset_status", v, 16'h0000);

    // Level trigger, rising through 0, wrapped ramp -512..511
    set_ctrl(8'h01);
    for (int i = 0; i < 1408; i++) begin
      adc_data  = 14'((i % 1024) - 512);
      adc_valid = 1'b1;
      @(negedge clk);
    end
    adc_valid = 1'b0;
    rd(16'hFFFF, v); chk("level_status", v, 16'hA100);
    rd(16'd128, v);  chk("level_idx128", v, 16'h0000);
    rd(16'd127, v);  chk("level_idx127", v, 16'hFFFF);
    rd(16'd0, v);    chk("level_idx0", v, 16'hFF80);
    rd(16'd1023, v); chk("level_idx1023", v, 16'hFF7F);

    // External trigger on sample 200, valid every third cycle
    set_ctrl(8'h00);
    set_ctrl(8'h05);
    for (int k = 0; k < 1096; k++) begin
      adc_data  = 14'(k - 300);
      adc_valid = 1'b1;
      ext_trig  = (k == 200);
      @(negedge clk);
      adc_valid = 1'b0;
      ext_trig  = 1'b0;
      cycles(2);
    end
    rd(16'hFFFF, v); chk("ext_status", v, 16'hA200);
    rd(16'd128, v);  chk("ext_idx128", v, 16'hFF9C);
    rd(16'd0, v);    chk("ext_idx0", v, 16'hFF1C);
    rd(16'd1023, v); chk("ext_idx1023", v, 16'h031B);
    rd(16'd1024, v); chk("ext_idx1024", v, 16'h0000);
    rd(16'h1234, v); chk("ext_idx_oob", v, 16'h0000);

    // Readout latency: previous index value persists for one cycle
    samplenum = 16'd128;
    @(negedge clk); chk("lat_cycle1_old", wavesample, 16'h0000);
    @(negedge clk); chk("lat_cycle2_new", wavesample, 16'hFF9C);

    // Force ignored in PRE, honoured in WAIT_TRIG; done after 896 samples
    set_ctrl(8'h00);
    set_ctrl(8'h01);
    send(50, 5);
    set_ctrl(8'h03);
    rd(16'hFFFF, v); chk("force_pre_ignored", v & 16'hF800, 16'h4800);
    set_ctrl(8'h01);
    send(78, 5);
    rd(16'hFFFF, v); chk("force_wait_state", v & 16'hF800, 16'h5000);
    set_ctrl(8'h03);
    rd(16'hFFFF, v); chk("force_post_status", v, 16'h5B00);
    send(895, 5);
    rd(16'hFFFF, v); chk("force_895_not_done", v, 16'h5B00);
    send(1, 5);
    rd(16'hFFFF, v); chk("force_896_done", v, 16'hA300);

    // Abort mid-POST, then re-arm
    set_ctrl(8'h00);
    set_ctrl(8'h01);
    send(128, 5);
    set_ctrl(8'h03);
    send(100, 5);
    samplenum = 16'hFFFF;
    set_ctrl(8'h13);
    chk("abort_status", wavesample & 16'hF800, 16'h0000);
    chk("abort_busy", {15'd0, busy}, 16'h0000);
    set_ctrl(8'h00);
    set_ctrl(8'h01);
    rd(16'hFFFF, v); chk("rearm_pre", v & 16'hF800, 16'h4800);

    // Reset in WAIT_TRIG
    send(128, 5);
    rd(16'hFFFF, v); chk("rst_wait_state", v & 16'hF800, 16'h5000);
    reset = 1'b1;
    ctrl  = 8'h00;
    @(negedge clk);
    chk("rst_mid_wavesample", wavesample, 16'h0000);
    chk("rst_mid_busy", {15'd0, busy}, 16'h0000);
    reset = 1'b0;
    rd(16'hFFFF, v); chk("rst_mid_status", v, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
